// File: rtl/ascon_finalization.sv
// ============================================================================
// ascon_finalization
// ----------------------------------------------------------------------------
// Closing stage of the Ascon-AEAD128 datapath. Accepts the 320-bit state left
// by the last data block together with the key, XORs the key into x2/x3, runs
// the 12-round Ascon permutation (ROUNDS_PER_CYCLE rounds per clock) and
// emits the 128-bit tag = {x3 ^ key[127:64], x4 ^ key[63:0]}.
//
// Parameters:
//   ROUNDS_PER_CYCLE  unrolled rounds per clock; one of 1, 2, 3, 4, 6, 12
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready input handshake (state + key)
//   x0_i..x4_i        incoming Ascon state words (64 bit each)
//   key               AEAD key, sampled only at acceptance
//   tag_valid/ready   output handshake
//   tag               computed tag, held until overwritten
//   busy              permutation in progress
//   tag_exp, tag_ok   expected tag / match flag (ASCON_FIN_TAG_VERIFY_EN only)
//
// Optional feature macro: ASCON_FIN_TAG_VERIFY_EN
//   When defined, tag_exp is sampled at acceptance and tag_ok reports a full
//   128-bit equality against the computed tag while tag_valid is high.
// ============================================================================
module ascon_finalization #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  x0_i,
    input  logic [63:0]  x1_i,
    input  logic [63:0]  x2_i,
    input  logic [63:0]  x3_i,
    input  logic [63:0]  x4_i,
    input  logic [127:0] key,
    output logic         tag_valid,
    input  logic         tag_ready,
    output logic [127:0] tag,
    output logic         busy
`ifdef ASCON_FIN_TAG_VERIFY_EN
    ,
    input  logic [127:0] tag_exp,
    output logic         tag_ok
`endif
);

    generate
        if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
              ROUNDS_PER_CYCLE == 3 || ROUNDS_PER_CYCLE == 4 ||
              ROUNDS_PER_CYCLE == 6 || ROUNDS_PER_CYCLE == 12)) begin : g_bad_param
            $error("ascon_finalization: ROUNDS_PER_CYCLE must be 1, 2, 3, 4, 6 or 12");
        end
    endgenerate

    localparam logic [3:0] RPC = 4'(ROUNDS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PERM = 2'd1,
        DONE = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Ascon round function helpers
    // ------------------------------------------------------------------
    function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // State packing: {x0, x1, x2, x3, x4}, x0 in the top 64 bits.
    function automatic logic [319:0] ascon_round(input logic [319:0] s,
                                                 input logic [3:0]   idx);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128];
        x3 = s[127:64];
        x4 = s[63:0];
        // Round constant 0xf0 - i*0x0f has the closed form {~i, i} for i < 16.
        x2[7:0] = x2[7:0] ^ {4'hf - idx, idx};
        // Substitution layer (bitsliced 5-bit S-box)
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        // Linear diffusion layer
        x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
        x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e         state_q, state_d;
    logic [319:0]   s_q;
    logic [127:0]   key_q;
    logic [3:0]     rnd_q;
    logic [127:0]   tag_q;

    // ------------------------------------------------------------------
    // Unrolled round chain: chain[0] is the registered state, each stage
    // applies one round with its own round index.
    // ------------------------------------------------------------------
    logic [319:0]   chain [ROUNDS_PER_CYCLE+1];
    logic [319:0]   s_next;
    logic [127:0]   tag_calc;
    logic           last_step;

    assign chain[0] = s_q;

    generate
        for (genvar gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_round
            assign chain[gi+1] = ascon_round(chain[gi], rnd_q + 4'(gi));
        end
    endgenerate

    assign s_next    = chain[ROUNDS_PER_CYCLE];
    assign tag_calc  = {s_next[127:64] ^ key_q[127:64], s_next[63:0] ^ key_q[63:0]};
    assign last_step = ((rnd_q + RPC) == 4'd12);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = PERM;
            PERM:    if (last_step) state_d = DONE;
            DONE:    if (tag_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        tag_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            PERM:    busy      = 1'b1;
            DONE:    tag_valid = 1'b1;
            default: ;
        endcase
    end

    assign tag = tag_q;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= '0;
            key_q <= '0;
            rnd_q <= '0;
            tag_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        s_q   <= {x0_i, x1_i, x2_i ^ key[127:64], x3_i ^ key[63:0], x4_i};
                        key_q <= key;
                        rnd_q <= '0;
                    end
                end
                PERM: begin
                    s_q   <= s_next;
                    rnd_q <= rnd_q + RPC;
                    if (last_step) begin
                        tag_q <= tag_calc;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ASCON_FIN_TAG_VERIFY_EN
    logic [127:0] tag_exp_q;
    logic         tag_ok_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_exp_q <= '0;
            tag_ok_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) tag_exp_q <= tag_exp;
                PERM: if (last_step) tag_ok_q <= (tag_calc == tag_exp_q);
                DONE: if (tag_ready) tag_ok_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign tag_ok = tag_ok_q;
`endif

endmodule

// File: tb/tb_ascon_finalization.sv
// ============================================================================
// tb_ascon_finalization
// ----------------------------------------------------------------------------
// Self-checking bench for ascon_finalization. Two instances are used: one
// with ROUNDS_PER_CYCLE=1 and one with ROUNDS_PER_CYCLE=4. Expected tags come
// from a table-driven software Ascon model and are queued on acceptance,
// then popped when the DUT raises tag_valid.
// ============================================================================
module tb_ascon_finalization;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid1, in_valid4;
    logic         tag_ready1, tag_ready4;
    logic [63:0]  x0, x1, x2, x3, x4;
    logic [127:0] key;

    logic         in_ready1, in_ready4;
    logic         tag_valid1, tag_valid4;
    logic [127:0] tag1, tag4;
    logic         busy1, busy4;
`ifdef ASCON_FIN_TAG_VERIFY_EN
    logic [127:0] tag_exp;
    logic         tag_ok1, tag_ok4;
`endif

    ascon_finalization #(.ROUNDS_PER_CYCLE(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .x0_i      (x0),
        .x1_i      (x1),
        .x2_i      (x2),
        .x3_i      (x3),
        .x4_i      (x4),
        .key       (key),
        .tag_valid (tag_valid1),
        .tag_ready (tag_ready1),
        .tag       (tag1),
        .busy      (busy1)
`ifdef ASCON_FIN_TAG_VERIFY_EN
        ,
        .tag_exp   (tag_exp),
        .tag_ok    (tag_ok1)
`endif
    );

    ascon_finalization #(.ROUNDS_PER_CYCLE(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .x0_i      (x0),
        .x1_i      (x1),
        .x2_i      (x2),
        .x3_i      (x3),
        .x4_i      (x4),
        .key       (key),
        .tag_valid (tag_valid4),
        .tag_ready (tag_ready4),
        .tag       (tag4),
        .busy      (busy4)
`ifdef ASCON_FIN_TAG_VERIFY_EN
        ,
        .tag_exp   (tag_exp),
        .tag_ok    (tag_ok4)
`endif
    );

    // Observation mux selecting the instance under test.
    bit           sel = 1'b0;
    logic         obs_ready, obs_valid, obs_busy;
    logic [127:0] obs_tag;
    assign obs_ready = sel ? in_ready4  : in_ready1;
    assign obs_valid = sel ? tag_valid4 : tag_valid1;
    assign obs_busy  = sel ? busy4      : busy1;
    assign obs_tag   = sel ? tag4       : tag1;

    int           checks = 0;
    int           errors = 0;
    logic [127:0] exp_q [$];

    // ------------------------------------------------------------------
    // Reference model: Ascon S-box as a lookup table (x0 = MSB of index)
    // ------------------------------------------------------------------
    function automatic logic [4:0] sbox(input logic [4:0] v);
        case (v)
            5'd0:  return 5'h04;  5'd1:  return 5'h0b;  5'd2:  return 5'h1f;  5'd3:  return 5'h14;
            5'd4:  return 5'h1a;  5'd5:  return 5'h15;  5'd6:  return 5'h09;  5'd7:  return 5'h02;
            5'd8:  return 5'h1b;  5'd9:  return 5'h05;  5'd10: return 5'h08;  5'd11: return 5'h12;
            5'd12: return 5'h1d;  5'd13: return 5'h03;  5'd14: return 5'h06;  5'd15: return 5'h1c;
            5'd16: return 5'h1e;  5'd17: return 5'h13;  5'd18: return 5'h07;  5'd19: return 5'h0e;
            5'd20: return 5'h00;  5'd21: return 5'h0d;  5'd22: return 5'h11;  5'd23: return 5'h18;
            5'd24: return 5'h10;  5'd25: return 5'h0c;  5'd26: return 5'h01;  5'd27: return 5'h19;
            5'd28: return 5'h16;  5'd29: return 5'h0a;  5'd30: return 5'h0f;  default: return 5'h17;
        endcase
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [127:0] model_tag(input logic [63:0] a0, input logic [63:0] a1,
                                               input logic [63:0] a2, input logic [63:0] a3,
                                               input logic [63:0] a4, input logic [127:0] k);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  col, o;
        x[0] = a0;
        x[1] = a1;
        x[2] = a2 ^ k[127:64];
        x[3] = a3 ^ k[63:0];
        x[4] = a4;
        for (int r = 0; r < 12; r++) begin
            x[2][7:0] = x[2][7:0] ^ 8'(240 - r * 15);
            for (int j = 0; j < 64; j++) begin
                col = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
                o = sbox(col);
                y[0][j] = o[4];
                y[1][j] = o[3];
                y[2][j] = o[2];
                y[3][j] = o[1];
                y[4][j] = o[0];
            end
            x[0] = y[0] ^ rotr(y[0], 19) ^ rotr(y[0], 28);
            x[1] = y[1] ^ rotr(y[1], 61) ^ rotr(y[1], 39);
            x[2] = y[2] ^ rotr(y[2], 1)  ^ rotr(y[2], 6);
            x[3] = y[3] ^ rotr(y[3], 10) ^ rotr(y[3], 17);
            x[4] = y[4] ^ rotr(y[4], 7)  ^ rotr(y[4], 41);
        end
        return {x[3] ^ k[127:64], x[4] ^ k[63:0]};
    endfunction

    // ------------------------------------------------------------------
    // Comparison helper
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // One operation on the selected instance: accept, time the latency, and
    // compare the tag against the scoreboard. key_after replaces the key on
    // the cycle after acceptance. The tag handshake is left to the caller.
    task automatic run_op(input bit s, input logic [63:0] a0, input logic [63:0] a1,
                          input logic [63:0] a2, input logic [63:0] a3, input logic [63:0] a4,
                          input logic [127:0] k, input logic [127:0] key_after,
                          input int latency, input string name);
        int cycles;
        int busy_cnt;
        logic [127:0] exp_tag;
        sel = s;
        @(negedge clk);
        x0 = a0; x1 = a1; x2 = a2; x3 = a3; x4 = a4; key = k;
        chk({name, "_in_ready"}, 128'(obs_ready), 128'd1);
        if (s) in_valid4 = 1'b1; else in_valid1 = 1'b1;
        exp_q.push_back(model_tag(a0, a1, a2, a3, a4, k));
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        in_valid4 = 1'b0;
        key = key_after;
        x0 = ~a0; x1 = ~a1; x2 = ~a2; x3 = ~a3; x4 = ~a4;
        chk({name, "_accept_in_ready"}, 128'(obs_ready), 128'd0);
        cycles   = 0;
        busy_cnt = obs_busy ? 1 : 0;
        while (!obs_valid && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
            if (obs_busy) busy_cnt++;
        end
        chk({name, "_latency"}, 128'(cycles), 128'(latency));
        chk({name, "_busy_cycles"}, 128'(busy_cnt), 128'(latency));
        exp_tag = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        chk({name, "_tag"}, obs_tag, exp_tag);
        $display("op %s: latency=%0d tag=%h", name, cycles, obs_tag);
    endtask

    task automatic handshake(input bit s, input string name);
        sel = s;
        if (s) tag_ready4 = 1'b1; else tag_ready1 = 1'b1;
        @(posedge clk);
        #1;
        tag_ready1 = 1'b0;
        tag_ready4 = 1'b0;
        chk({name, "_hs_tag_valid"}, 128'(obs_valid), 128'd0);
        chk({name, "_hs_in_ready"}, 128'(obs_ready), 128'd1);
    endtask

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B = 128'hfedcba98765432100f1e2d3c4b5a6978;
    localparam logic [63:0]  PAT   = 64'h0123456789abcdef;

    logic [127:0] held_tag;

    initial begin
        rst_n      = 1'b0;
        in_valid1  = 1'b0;
        in_valid4  = 1'b0;
        tag_ready1 = 1'b0;
        tag_ready4 = 1'b0;
        x0 = '0; x1 = '0; x2 = '0; x3 = '0; x4 = '0;
        key = '0;
`ifdef ASCON_FIN_TAG_VERIFY_EN
        tag_exp = '0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state of both instances
        chk("rst_in_ready1",  128'(in_ready1),  128'd1);
        chk("rst_tag_valid1", 128'(tag_valid1), 128'd0);
        chk("rst_busy1",      128'(busy1),      128'd0);
        chk("rst_tag1",       tag1,             128'd0);
        chk("rst_in_ready4",  128'(in_ready4),  128'd1);
        chk("rst_tag4",       tag4,             128'd0);
`ifdef ASCON_FIN_TAG_VERIFY_EN
        chk("rst_tag_ok1",    128'(tag_ok1),    128'd0);
`endif

        // All-zero state and key, 1 round/cycle
        run_op(1'b0, '0, '0, '0, '0, '0, '0, '0, 12, "zero_r1");
        handshake(1'b0, "zero_r1");

        // Patterned state, golden key, on both instances
        run_op(1'b0, PAT, ~PAT, {PAT[31:0], PAT[63:32]}, PAT ^ 64'hffff0000ffff0000, 64'h8000000000000001,
               KEY_A, KEY_A, 12, "pat_r1");
        handshake(1'b0, "pat_r1");
        run_op(1'b1, PAT, ~PAT, {PAT[31:0], PAT[63:32]}, PAT ^ 64'hffff0000ffff0000, 64'h8000000000000001,
               KEY_A, KEY_A, 3, "pat_r4");
        handshake(1'b1, "pat_r4");
        run_op(1'b1, PAT, PAT, PAT, PAT, PAT, KEY_B, KEY_B, 3, "same_r4");
        handshake(1'b1, "same_r4");

        // Hold tag_ready low: tag stable, in_valid ignored
        run_op(1'b0, PAT, PAT, PAT, PAT, PAT, KEY_A, KEY_A, 12, "hold");
        held_tag = tag1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                x0 = 64'hdead; key = KEY_B; in_valid1 = 1'b1;
            end else begin
                in_valid1 = 1'b0;
            end
            @(posedge clk);
            #1;
            chk("hold_tag_valid", 128'(tag_valid1), 128'd1);
            chk("hold_in_ready",  128'(in_ready1),  128'd0);
            chk("hold_tag",       tag1,             held_tag);
        end
        in_valid1 = 1'b0;
        handshake(1'b0, "hold");
        chk("hold_tag_after_hs", tag1, held_tag);
        chk("hold_no_extra_op",  128'(busy1), 128'd0);
        run_op(1'b0, 64'h1, 64'h2, 64'h3, 64'h4, 64'h5, KEY_B, KEY_B, 12, "after_hold");
        handshake(1'b0, "after_hold");

        // Reset asserted around round 6 of an operation
        sel = 1'b0;
        @(negedge clk);
        x0 = PAT; x1 = PAT; x2 = PAT; x3 = PAT; x4 = PAT; key = KEY_A;
        in_valid1 = 1'b1;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_tag_valid", 128'(tag_valid1), 128'd0);
        chk("abort_busy",      128'(busy1),      128'd0);
        chk("abort_tag",       tag1,             128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready",  128'(in_ready1),  128'd1);
        run_op(1'b0, PAT, 64'h0, PAT, 64'h0, PAT, KEY_A, KEY_A, 12, "post_abort");
        handshake(1'b0, "post_abort");

        // Key changed the cycle after acceptance has no effect
        run_op(1'b0, 64'h11, 64'h22, 64'h33, 64'h44, 64'h55, KEY_A, KEY_B, 12, "key_change_r1");
        handshake(1'b0, "key_change_r1");
        run_op(1'b1, 64'h11, 64'h22, 64'h33, 64'h44, 64'h55, KEY_B, KEY_A, 3, "key_change_r4");
        handshake(1'b1, "key_change_r4");

`ifdef ASCON_FIN_TAG_VERIFY_EN
        // Tag verification: match, mismatch in bit 0, clear after handshake
        tag_exp = model_tag(PAT, PAT, PAT, PAT, PAT, KEY_B);
        run_op(1'b0, PAT, PAT, PAT, PAT, PAT, KEY_B, KEY_B, 12, "verify_ok");
        chk("verify_ok_tag_ok", 128'(tag_ok1), 128'd1);
        handshake(1'b0, "verify_ok");
        chk("verify_ok_cleared", 128'(tag_ok1), 128'd0);
        tag_exp = model_tag(PAT, PAT, PAT, PAT, PAT, KEY_B) ^ 128'd1;
        run_op(1'b0, PAT, PAT, PAT, PAT, PAT, KEY_B, KEY_B, 12, "verify_bad");
        chk("verify_bad_tag_ok", 128'(tag_ok1), 128'd0);
        handshake(1'b0, "verify_bad");
        tag_exp = model_tag(64'h1, 64'h2, 64'h3, 64'h4, 64'h5, KEY_A);
        run_op(1'b1, 64'h1, 64'h2, 64'h3, 64'h4, 64'h5, KEY_A, KEY_A, 3, "verify_ok_r4");
        chk("verify_ok_r4_tag_ok", 128'(tag_ok4), 128'd1);
        handshake(1'b1, "verify_ok_r4");
        chk("verify_ok_r4_cleared", 128'(tag_ok4), 128'd0);
`endif

        chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
